alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares one integer ALU instance (alu, ops from core_types_pkg::alu_op_t) between NUM_REQ independent requesters, e.g. the execute stage, the address-generation path and the debug unit.
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- Grants are round-robin. At most one operation is in flight at a time.
- Operands are registered at accept, and the result is registered before it is returned.

Parameters:
- NUM_REQ, default 2, number of requesters; legal range 2..4.
- IDX_W, default $clog2(NUM_REQ), width of grant and owner index; derived, never overridden.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst  input  1  asynchronous active-high reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester request accept; at most one bit set.
- req_op1  input  NUM_REQ x 32  operand 1 per requester, signed.
- req_op2  input  NUM_REQ x 32  operand 2 per requester, signed.
- req_alu_op  input  NUM_REQ x alu_op_t  operation per requester.
- resp_valid  output  NUM_REQ  one-hot response valid, set only for the owning requester.
- resp_ready  input  NUM_REQ  per-requester response accept.
- resp_data  output  32  result; shared by all requesters, meaningful only while a resp_valid bit is set.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Clock and reset: single clock clk. Reset rst is asynchronous, active-high.
- Reset values:
  - state = IDLE, rr_ptr = 0, owner = 0.
  - op1_q, op2_q and result_q = 0; op_q = ALU_ADD.
  - req_ready, resp_valid and busy all 0.
- Reset mid-operation: any in-flight op is discarded with no response. The first grant after reset follows rr_ptr = 0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Arbitration scans requesters starting at index rr_ptr, wrapping modulo NUM_REQ. The first i with req_valid[i] = 1 is granted.
  - req_ready[i] = 1 combinationally, for the granted i only.
  - A handshake occurs when req_valid[i] && req_ready[i]. On the handshake edge:
    - op1_q, op2_q and op_q capture requester i's inputs; owner = i.
    - rr_ptr = (i + 1) mod NUM_REQ.
    - Go to EXEC.
  - If no req_valid bit is set: stay in IDLE, rr_ptr unchanged.
- EXEC:
  - ALU is driven from op1_q, op2_q and op_q.
  - result_q captures the ALU output. Go to RESP.
- RESP:
  - resp_valid[owner] = 1 and resp_data = result_q.
  - Both are held stable until resp_ready[owner] = 1. resp_ready bits of non-owners are ignored.
  - On the handshake edge, go to IDLE.
  - No new request is accepted in the same cycle as a response handshake.
- req_ready is 0 in EXEC and in RESP.
- Latency: accept at edge T gives resp_valid high in the cycle after edge T+1, i.e. 2 cycles. Minimum issue interval is 3 cycles.
- Requester contract: a requester must hold req_valid and its operands stable until accepted. Dropping req_valid before accept is legal: that requester is simply not granted.
- Arithmetic: exactly as alu_op_t defines.
  - Shifts use op2[4:0]. SLT is signed, SLTU is unsigned.
  - Unknown encodings give 0.
  - Wrap-around is modulo 2^32; no overflow flag.
- Fairness: a requester that is continuously valid is granted within NUM_REQ grants.

Optional Feature:
- Macro: ALU_SHARE_ARBITER_FAST_EN.
- Defined:
  - EXEC is removed. At the request handshake, result_q captures the ALU output computed directly from the granted requester's inputs, and the FSM goes straight to RESP.
  - Latency is 1 cycle; minimum issue interval is 2 cycles.
  - Operand registers are not instantiated.
- Undefined: the 3-state behaviour above.
- Arbitration, handshakes and reset are identical in both builds.

Test Plan:
- Single op: after reset, req0 ALU_ADD, op1 = 5, op2 = 7 → req_ready[0] = 1 in the same cycle; resp_valid[0] = 1 and resp_data = 12 two cycles later (one cycle with FAST_EN); busy = 1 throughout.
- Contention: req0 and req1 both valid from reset, req0 ALU_SUB 10 − 3, req1 ALU_SRA 0xFFFFFFF8 by 1 → req0 served first with 7; req1 served next with 0xFFFFFFFC; a third req0 issued afterwards is granted only after req1's response handshake.
- Backpressure: req1 ALU_SLTU op1 = 0xFFFFFFFF, op2 = 1; hold resp_ready[1] = 0 for 5 cycles → resp_valid[1] and resp_data = 0 stay stable; req_ready = 0 throughout even with req0 valid; release → IDLE next cycle, then req0 granted.
- Wrong-owner ready: owner = 0; assert resp_ready[1] only → no handshake; state stays RESP.
- Reset mid-op: assert rst while in EXEC with ALU_XOR 0xF0F0 ^ 0x0FF0 pending → all outputs 0 asynchronously; no response after rst deasserts; a subsequent req1 returns correct results.
- Opcode sweep: every alu_op_t value plus one illegal encoding (with op1 = −1, op2 = 33) → results match the reference model; shift amount 1 (33 & 31); illegal encoding returns 0.

Source files
------------

// File: rtl/core_types_pkg.sv
// Shared core type definitions.
// alu_op_t: integer ALU operation encoding used by every ALU requester.
// Encodings 10..15 are unassigned; the ALU returns 0 for them.
package core_types_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_t;

endpackage

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: one integer ALU shared round-robin between NUM_REQ
// requesters, each with a valid/ready request and valid/ready response
// channel. One operation in flight at a time; result registered before return.
//
// Build option: define ALU_SHARE_ARBITER_FAST_EN to drop the EXEC state and
// the operand registers (ALU fed straight from the granted requester, result
// captured at accept, 1-cycle latency). Default build: IDLE -> EXEC -> RESP.
//
// Ports:
//   clk            core clock, rising edge
//   rst            asynchronous active-high reset
//   req_valid_i    per-requester request valid
//   req_ready_o    per-requester request accept (at most one bit set)
//   req_op1_i      per-requester operand 1 (32 bit)
//   req_op2_i      per-requester operand 2 (32 bit)
//   req_alu_op_i   per-requester ALU operation
//   resp_valid_o   one-hot response valid for the owning requester
//   resp_ready_i   per-requester response accept (only owner's bit matters)
//   resp_data_o    shared result bus, valid while a resp_valid_o bit is set
//   busy_o         high whenever the FSM is not IDLE
module alu_share_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_REQ-1:0]                  req_valid_i,
  output logic [NUM_REQ-1:0]                  req_ready_o,
  input  logic [NUM_REQ-1:0][31:0]            req_op1_i,
  input  logic [NUM_REQ-1:0][31:0]            req_op2_i,
  input  core_types_pkg::alu_op_t [NUM_REQ-1:0] req_alu_op_i,
  output logic [NUM_REQ-1:0]                  resp_valid_o,
  input  logic [NUM_REQ-1:0]                  resp_ready_i,
  output logic [31:0]                         resp_data_o,
  output logic                                busy_o
);
  import core_types_pkg::*;

`ifdef ALU_SHARE_ARBITER_FAST_EN
  typedef enum logic [1:0] {IDLE, RESP} state_t;
`else
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
`endif

  state_t           state_q;
  logic [IDX_W-1:0] rr_ptr_q;
  logic [IDX_W-1:0] owner_q;
  logic [31:0]      result_q;

  logic [IDX_W-1:0] cand;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_found;
  logic             accept;
  logic             resp_hs;
  logic [IDX_W-1:0] rr_ptr_d;
  logic [31:0]      alu_a;
  logic [31:0]      alu_b;
  alu_op_t          alu_op;
  logic [31:0]      alu_res;

`ifndef ALU_SHARE_ARBITER_FAST_EN
  logic [31:0]      op1_q;
  logic [31:0]      op2_q;
  alu_op_t          op_q;
`endif

  function automatic logic [31:0] alu_f(alu_op_t op, logic [31:0] a, logic [31:0] b);
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_XOR:  return a ^ b;
      ALU_SLL:  return a << b[4:0];
      ALU_SRL:  return a >> b[4:0];
      ALU_SRA:  return $signed(a) >>> b[4:0];
      ALU_SLT:  return {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: return {31'b0, a < b};
      default:  return '0;
    endcase
  endfunction

  // Round-robin scan starting at rr_ptr_q; first valid requester wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned k = 0; k < 32'(NUM_REQ); k++) begin
      cand = IDX_W'((32'(rr_ptr_q) + k) % 32'(NUM_REQ));
      if (!grant_found && req_valid_i[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Ready is held low while reset is asserted so all outputs read 0 in reset.
  always_comb begin
    req_ready_o = '0;
    if (state_q == IDLE && grant_found && !rst)
      req_ready_o[grant_idx] = 1'b1;
  end

  always_comb begin
    resp_valid_o = '0;
    if (state_q == RESP)
      resp_valid_o[owner_q] = 1'b1;
  end

  assign accept      = |(req_valid_i & req_ready_o);
  assign resp_hs     = (state_q == RESP) && resp_ready_i[owner_q];
  assign rr_ptr_d    = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
  assign resp_data_o = result_q;
  assign busy_o      = (state_q != IDLE);

`ifdef ALU_SHARE_ARBITER_FAST_EN
  assign alu_a  = req_op1_i[grant_idx];
  assign alu_b  = req_op2_i[grant_idx];
  assign alu_op = req_alu_op_i[grant_idx];
`else
  assign alu_a  = op1_q;
  assign alu_b  = op2_q;
  assign alu_op = op_q;
`endif

  assign alu_res = alu_f(alu_op, alu_a, alu_b);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      result_q <= '0;
`ifndef ALU_SHARE_ARBITER_FAST_EN
      op1_q    <= '0;
      op2_q    <= '0;
      op_q     <= ALU_ADD;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            owner_q  <= grant_idx;
            rr_ptr_q <= rr_ptr_d;
`ifdef ALU_SHARE_ARBITER_FAST_EN
            result_q <= alu_res;
            state_q  <= RESP;
`else
            op1_q    <= req_op1_i[grant_idx];
            op2_q    <= req_op2_i[grant_idx];
            op_q     <= req_alu_op_i[grant_idx];
            state_q  <= EXEC;
`endif
          end
        end
`ifndef ALU_SHARE_ARBITER_FAST_EN
        EXEC: begin
          result_q <= alu_res;
          state_q  <= RESP;
        end
`endif
        RESP: begin
          if (resp_hs)
            state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;
  import core_types_pkg::*;

  localparam int N = 2;
`ifdef ALU_SHARE_ARBITER_FAST_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid, req_ready, resp_valid, resp_ready;
  logic [N-1:0][31:0] req_op1, req_op2;
  alu_op_t [N-1:0]   req_alu_op;
  logic [31:0]       resp_data;
  logic              busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.NUM_REQ(N)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_op1_i(req_op1), .req_op2_i(req_op2), .req_alu_op_i(req_alu_op),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_data_o(resp_data), .busy_o(busy)
  );

  // Reference ALU written with plain arithmetic (multiply/divide by powers of two).
  function automatic logic [31:0] ref_alu(alu_op_t op, logic [31:0] a, logic [31:0] b);
    logic [31:0] p;
    p = 32'd1 << (b % 32);
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_XOR:  return a ^ b;
      ALU_SLL:  return a * p;
      ALU_SRL:  return a / p;
      ALU_SRA:  return a[31] ? ~((~a) / p) : a / p;
      ALU_SLT:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
      default:  return 32'd0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0; resp_ready = '0;
    req_op1 = '0; req_op2 = '0;
    req_alu_op[0] = ALU_ADD; req_alu_op[1] = ALU_ADD;
    tick(); tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic wait_resp(output bit to);
    int w = 0;
    while (resp_valid == '0 && w < 20) begin tick(); w++; end
    to = (resp_valid == '0);
  endtask

  // Drives one full transaction; returns observed result, latency, timeout flag.
  task automatic issue(input logic [0:0] r, input alu_op_t op, input logic [31:0] a,
                       input logic [31:0] b, output logic [31:0] res, output int lat,
                       output bit to);
    int w = 0;
    to = 1'b0;
    req_valid[r] = 1'b1; req_op1[r] = a; req_op2[r] = b; req_alu_op[r] = op;
    #1;
    while (!req_ready[r] && w < 20) begin tick(); w++; end
    if (!req_ready[r]) to = 1'b1;
    tick();
    req_valid[r] = 1'b0;
    lat = 1;
    while (!resp_valid[r] && lat < 20) begin tick(); lat++; end
    if (!resp_valid[r]) to = 1'b1;
    res = resp_data;
    resp_ready[r] = 1'b1;
    tick();
    resp_ready[r] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '1; resp_ready = '1;
    #1;
    tests++; if (req_ready !== 2'b00) begin fails++; $display("FAIL reset_req_ready: got %b expected 00", req_ready); end
    tests++; if (resp_valid !== 2'b00) begin fails++; $display("FAIL reset_resp_valid: got %b expected 00", resp_valid); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tests++; if (resp_data !== 32'd0) begin fails++; $display("FAIL reset_resp_data: got %h expected 0", resp_data); end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    req_valid[0] = 1'b1; req_op1[0] = 32'd5; req_op2[0] = 32'd7; req_alu_op[0] = ALU_ADD;
    #1;
    tests++; if (req_ready !== 2'b01) begin fails++; $display("FAIL single_ready: got %b expected 01", req_ready); end
    tick();
    req_valid[0] = 1'b0;
    #1;
    for (int c = 1; c < LAT; c++) begin
      tests++;
      if (resp_valid !== 2'b00 || busy !== 1'b1) begin
        fails++; $display("FAIL single_exec: resp_valid %b busy %b expected 00/1", resp_valid, busy);
      end
      tick();
    end
    tests++; if (resp_valid !== 2'b01) begin fails++; $display("FAIL single_resp_valid: got %b expected 01", resp_valid); end
    tests++; if (resp_data !== 32'd12) begin fails++; $display("FAIL single_data: got %h expected %h", resp_data, 32'd12); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL single_busy: got %b expected 1", busy); end
    resp_ready[0] = 1'b1; tick(); resp_ready[0] = 1'b0; #1;
    tests++; if (busy !== 1'b0 || resp_valid !== 2'b00) begin fails++; $display("FAIL single_idle: busy %b resp_valid %b expected 0/00", busy, resp_valid); end
  endtask

  task automatic test_contention();
    bit to;
    do_reset();
    req_valid = 2'b11;
    req_op1[0] = 32'd10; req_op2[0] = 32'd3; req_alu_op[0] = ALU_SUB;
    req_op1[1] = 32'hFFFFFFF8; req_op2[1] = 32'd1; req_alu_op[1] = ALU_SRA;
    #1;
    tests++; if (req_ready !== 2'b01) begin fails++; $display("FAIL cont_grant0: got %b expected 01", req_ready); end
    tick(); req_valid[0] = 1'b0; #1;
    tests++; if (req_ready !== 2'b00) begin fails++; $display("FAIL cont_busy_ready: got %b expected 00", req_ready); end
    wait_resp(to);
    tests++; if (to !== 1'b0) begin fails++; $display("FAIL cont_timeout0: got %b expected 0", to); end
    tests++; if (resp_valid !== 2'b01 || resp_data !== ref_alu(ALU_SUB, 32'd10, 32'd3)) begin
      fails++; $display("FAIL cont_resp0: valid %b data %h expected 01 %h", resp_valid, resp_data, ref_alu(ALU_SUB, 32'd10, 32'd3));
    end
    resp_ready[0] = 1'b1; tick(); resp_ready[0] = 1'b0;
    req_valid[0] = 1'b1; req_op1[0] = 32'd1; req_op2[0] = 32'd2; req_alu_op[0] = ALU_ADD;
    #1;
    tests++; if (req_ready !== 2'b10) begin fails++; $display("FAIL cont_grant1: got %b expected 10", req_ready); end
    tick(); req_valid[1] = 1'b0; #1;
    tests++; if (req_ready !== 2'b00) begin fails++; $display("FAIL cont_hold0: got %b expected 00", req_ready); end
    wait_resp(to);
    tests++; if (to !== 1'b0 || resp_valid !== 2'b10 || resp_data !== 32'hFFFFFFFC) begin
      fails++; $display("FAIL cont_resp1: to %b valid %b data %h expected 0 10 fffffffc", to, resp_valid, resp_data);
    end
    tests++; if (req_ready !== 2'b00) begin fails++; $display("FAIL cont_resp_ready: got %b expected 00", req_ready); end
    resp_ready[1] = 1'b1; tick(); resp_ready[1] = 1'b0; #1;
    tests++; if (req_ready !== 2'b01) begin fails++; $display("FAIL cont_grant0b: got %b expected 01", req_ready); end
    tick(); req_valid[0] = 1'b0;
    wait_resp(to);
    tests++; if (to !== 1'b0 || resp_valid !== 2'b01 || resp_data !== 32'd3) begin
      fails++; $display("FAIL cont_resp0b: to %b valid %b data %h expected 0 01 3", to, resp_valid, resp_data);
    end
    resp_ready[0] = 1'b1; tick(); resp_ready[0] = 1'b0;
  endtask

  task automatic test_backpressure();
    bit to;
    do_reset();
    req_valid[1] = 1'b1; req_op1[1] = 32'hFFFFFFFF; req_op2[1] = 32'd1; req_alu_op[1] = ALU_SLTU;
    #1;
    tests++; if (req_ready !== 2'b10) begin fails++; $display("FAIL bp_grant: got %b expected 10", req_ready); end
    tick();
    req_valid[1] = 1'b0;
    req_valid[0] = 1'b1; req_op1[0] = 32'd4; req_op2[0] = 32'd4; req_alu_op[0] = ALU_ADD;
    wait_resp(to);
    tests++; if (to !== 1'b0) begin fails++; $display("FAIL bp_timeout: got %b expected 0", to); end
    for (int c = 0; c < 5; c++) begin
      tests++;
      if (resp_valid !== 2'b10 || resp_data !== 32'd0 || req_ready !== 2'b00) begin
        fails++; $display("FAIL bp_hold: valid %b data %h ready %b expected 10 0 00", resp_valid, resp_data, req_ready);
      end
      tick();
    end
    resp_ready[1] = 1'b1; #1;
    tests++; if (req_ready !== 2'b00) begin fails++; $display("FAIL bp_hs_ready: got %b expected 00", req_ready); end
    tick(); resp_ready[1] = 1'b0; #1;
    tests++; if (busy !== 1'b0 || req_ready !== 2'b01) begin fails++; $display("FAIL bp_release: busy %b ready %b expected 0 01", busy, req_ready); end
    tick(); req_valid[0] = 1'b0;
    wait_resp(to);
    tests++; if (to !== 1'b0 || resp_valid !== 2'b01 || resp_data !== 32'd8) begin
      fails++; $display("FAIL bp_resp0: to %b valid %b data %h expected 0 01 8", to, resp_valid, resp_data);
    end
    resp_ready[0] = 1'b1; tick(); resp_ready[0] = 1'b0;
  endtask

  task automatic test_wrong_owner();
    bit to;
    do_reset();
    req_valid[0] = 1'b1; req_op1[0] = 32'h1200; req_op2[0] = 32'h34; req_alu_op[0] = ALU_OR;
    #1; tick(); req_valid[0] = 1'b0;
    wait_resp(to);
    resp_ready = 2'b10;
    for (int c = 0; c < 3; c++) tick();
    tests++; if (to !== 1'b0 || resp_valid !== 2'b01 || busy !== 1'b1 || resp_data !== 32'h1234) begin
      fails++; $display("FAIL wrong_owner: to %b valid %b busy %b data %h expected 0 01 1 1234", to, resp_valid, busy, resp_data);
    end
    resp_ready = 2'b01; tick(); resp_ready = '0; #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL wrong_owner_release: busy %b expected 0", busy); end
  endtask

  task automatic test_reset_midop();
    logic [31:0] res, a, b;
    int lat;
    bit to;
    do_reset();
    req_valid[0] = 1'b1; req_op1[0] = 32'hF0F0; req_op2[0] = 32'h0FF0; req_alu_op[0] = ALU_XOR;
    #1; tick(); req_valid[0] = 1'b0;
    rst = 1'b1; #1;
    tests++; if (req_ready !== 2'b00 || resp_valid !== 2'b00 || busy !== 1'b0 || resp_data !== 32'd0) begin
      fails++; $display("FAIL midop_reset: ready %b valid %b busy %b data %h expected all 0", req_ready, resp_valid, busy, resp_data);
    end
    tick(); rst = 1'b0; #1;
    for (int c = 0; c < 4; c++) begin
      tests++; if (resp_valid !== 2'b00) begin fails++; $display("FAIL midop_no_resp: got %b expected 00", resp_valid); end
      tick();
    end
    a = $urandom; b = $urandom;
    issue(1'b1, ALU_SUB, a, b, res, lat, to);
    tests++; if (to !== 1'b0 || res !== ref_alu(ALU_SUB, a, b)) begin
      fails++; $display("FAIL midop_after: to %b got %h expected %h", to, res, ref_alu(ALU_SUB, a, b));
    end
  endtask

  task automatic test_opcode_sweep();
    logic [31:0] res;
    int lat;
    bit to;
    alu_op_t op;
    do_reset();
    for (int o = 0; o < 11; o++) begin
      op = (o == 10) ? alu_op_t'(4'hF) : alu_op_t'(4'(o));
      issue(1'b0, op, 32'hFFFFFFFF, 32'd33, res, lat, to);
      tests++;
      if (to !== 1'b0 || lat != LAT || res !== ref_alu(op, 32'hFFFFFFFF, 32'd33)) begin
        fails++; $display("FAIL sweep_op%0d: to %b lat %0d got %h expected lat %0d %h", o, to, lat, res, LAT, ref_alu(op, 32'hFFFFFFFF, 32'd33));
      end
    end
  endtask

  task automatic test_random();
    logic [N-1:0] mask, oh;
    logic [0:0]   gi;
    logic [31:0]  exp;
    int ptr, g;
    bit to;
    do_reset();
    ptr = 0;
    for (int it = 0; it < 60; it++) begin
      mask = 2'($urandom_range(0, 3));
      for (int r = 0; r < N; r++) begin
        req_op1[1'(r)] = $urandom; req_op2[1'(r)] = $urandom;
        req_alu_op[1'(r)] = alu_op_t'(4'($urandom_range(0, 15)));
      end
      req_valid = mask;
      #1;
      oh = '0;
      g = -1;
      for (int k = 0; k < N; k++)
        if (g < 0 && mask[1'((ptr + k) % N)]) g = (ptr + k) % N;
      if (g >= 0) begin gi = 1'(g); oh[gi] = 1'b1; end
      tests++; if (req_ready !== oh) begin fails++; $display("FAIL rand_grant it%0d: got %b expected %b", it, req_ready, oh); end
      if (g < 0) begin
        tick();
      end else begin
        exp = ref_alu(req_alu_op[gi], req_op1[gi], req_op2[gi]);
        tick();
        req_valid = '0;
        wait_resp(to);
        if ($urandom_range(0, 1) == 1) begin resp_ready = ~oh; tick(); end
        tests++;
        if (to !== 1'b0 || resp_valid !== oh || resp_data !== exp) begin
          fails++; $display("FAIL rand_resp it%0d: to %b valid %b data %h expected 0 %b %h", it, to, resp_valid, resp_data, oh, exp);
        end
        resp_ready = oh; tick(); resp_ready = '0;
        ptr = (g + 1) % N;
      end
    end
    req_valid = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    do_reset();
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_wrong_owner();
    test_reset_midop();
    test_opcode_sweep();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
